muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit inside the execute stage. It accepts one operation from the execute stage and computes it over several cycles, stalling the front of the pipeline through the hazard unit while it works. Its result is muxed onto the execute-stage ALU result, so it reaches the memory stage's ALU-result field and write-back through the normal path.

---
 rtl/muldiv_unit.sv | 158 +++++++++++++++
 tb/tb_muldiv_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, with a single-cycle path for divide-by-zero and signed overflow.
//
// state  | meaning
// S_IDLE | no operation
// S_CALC | iterating, one product/quotient bit per cycle
// S_DONE | result ready, one-cycle done
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              accept, last_iter;
  logic              a_signed, b_signed, sa_in, sb_in;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf, fast;
  logic [XLEN-1:0]   fast_res;
  logic [XLEN:0]     mul_sum, div_cand, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] mul_acc, div_acc, iter_acc, prod_fix;
  logic [XLEN-1:0]   quo, rem, final_res;

  assign accept    = start && !flush && (state_q != S_CALC);
  assign last_iter = (cnt_q == CW'(1));

  // Operand conditioning: signed inputs become magnitudes plus a recorded sign.
  always_comb begin
    a_signed = funct3[2] ? !funct3[0] : (funct3 != 3'd3);
    b_signed = funct3[2] ? !funct3[0] : !funct3[1];
    sa_in    = a_signed && a[XLEN-1];
    sb_in    = b_signed && b[XLEN-1];
    a_mag    = sa_in ? -a : a;
    b_mag    = sb_in ? -b : b;
    div_zero = funct3[2] && (b == '0);
    div_ovf  = funct3[2] && !funct3[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    fast     = div_zero || div_ovf;
    if (div_zero) fast_res = funct3[1] ? a : '1;
    else          fast_res = funct3[1] ? '0 : a;
  end

  // Multiply keeps the running product in acc; divide keeps {remainder, dividend/quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (opb_q[0] ? {1'b0, opa_q} : '0);
    mul_acc  = {mul_sum, acc_q[XLEN-1:1]};
    div_cand = acc_q[2*XLEN-1:XLEN-1];
    div_diff = div_cand - {1'b0, opa_q};
    div_ge   = (div_cand >= {1'b0, opa_q});
    div_acc  = {(div_ge ? div_diff[XLEN-1:0] : div_cand[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    iter_acc = op_q[2] ? div_acc : mul_acc;
    prod_fix = (sa_q ^ sb_q) ? -iter_acc : iter_acc;
    quo      = iter_acc[XLEN-1:0];
    rem      = iter_acc[2*XLEN-1:XLEN];
    case (op_q)
      3'd0:          final_res = prod_fix[XLEN-1:0];
      3'd4:          final_res = (sa_q ^ sb_q) ? -quo : quo;
      3'd5:          final_res = quo;
      3'd6:          final_res = sa_q ? -rem : rem;
      3'd7:          final_res = rem;
      default:       final_res = prod_fix[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = fast ? S_DONE : S_CALC;
        S_CALC:  if (last_iter) state_d = S_DONE;
        S_DONE:  state_d = start ? (fast ? S_DONE : S_CALC) : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    result_d = result_q;
    if (accept) begin
      op_d  = funct3;
      sa_d  = sa_in;
      sb_d  = sb_in;
      cnt_d = CW'(XLEN);
      opa_d = funct3[2] ? b_mag : a_mag;
      opb_d = b_mag;
      acc_d = funct3[2] ? {{XLEN{1'b0}}, a_mag} : '0;
      if (fast) result_d = fast_res;
    end else if (state_q == S_CALC && !flush) begin
      cnt_d = cnt_q - CW'(1);
      opb_d = opb_q >> 1;
      acc_d = iter_acc;
      if (last_iter) result_d = final_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    busy   = (state_q == S_CALC);
    done   = (state_q == S_DONE);
    result = result_q;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, results, fast paths, flush, reset and ordering.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] result;

  int total = 0;
  int bad = 0;
  int overlap = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; start is sampled at the following posedge (edge k).
  task automatic issue(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv);
    funct3 = f; a = av; b = bv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns the number of negedges after edge k until done (0 on timeout).
  task automatic wait_done(output int lat, output int nbusy);
    int i;
    lat = 0; nbusy = 0; i = 0;
    while (lat == 0 && i < 40) begin
      @(negedge clk);
      i++;
      if (busy && done) overlap++;
      if (busy) nbusy++;
      if (done) lat = i;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] exp_r, input int exp_lat);
    int lat, nb;
    issue(f, av, bv);
    wait_done(lat, nb);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_busy"}, nb, (exp_lat == 1) ? 0 : 32);
    chk({tag, "_res"}, result, exp_r);
  endtask

  initial begin
    int lat, nb, nd, first;
    #3 rst_n = 1'b0;
    #10;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    run_op("mul", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    @(negedge clk);
    chk("done_pulse_end", done, 0);
    run_op("mulh",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run_op("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
    run_op("div",    3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_op("rem",    3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_op("divu",   3'd5, 32'd100,      32'd7,        32'd14,       33);
    run_op("remu",   3'd7, 32'd100,      32'd7,        32'd2,        33);
    run_op("divu_by0", 3'd5, 32'd55, 32'd0, 32'hFFFFFFFF, 1);
    @(negedge clk);
    chk("fast_done_end", done, 0);
    run_op("rem_by0", 3'd6, 32'd5, 32'd0, 32'd5, 1);
    @(negedge clk);

    // flush mid-DIVU: no done, result stays 5
    issue(3'd5, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_busy", busy, 0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("flush_no_done", nd, 0);
    chk("flush_result", result, 32'd5);

    // start with flush in IDLE: a fast-path op that must not be taken
    funct3 = 3'd5; a = 32'd100; b = 32'd0; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 begin start = 1'b0; flush = 1'b0; end
    @(negedge clk);
    chk("stflush_busy", busy, 0);
    chk("stflush_done", done, 0);
    chk("stflush_result", result, 32'd5);

    run_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1);
    @(negedge clk);

    // start pulses during CALC are ignored
    issue(3'd5, 32'd100, 32'd7);
    nd = 0; first = 0;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (busy && done) overlap++;
      if (done) begin
        nd++;
        if (first == 0) first = i;
      end
      start = (i == 5 || i == 20);
      funct3 = 3'd0; a = 32'd3; b = 32'd3;
    end
    start = 1'b0;
    chk("ign_ndone", nd, 1);
    chk("ign_lat", first, 33);
    chk("ign_res", result, 32'd14);

    // back-to-back start in the DONE cycle
    run_op("b2b_first", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    issue(3'd4, 32'hFFFFFFF9, 32'd2);
    chk("b2b_busy", busy, 1);
    chk("b2b_hold", result, 32'hFFFFFFEB);
    wait_done(lat, nb);
    chk("b2b_lat", lat, 33);
    chk("b2b_res", result, 32'hFFFFFFFD);

    // async reset mid-CALC, then a start on the first edge after release
    issue(3'd0, 32'd7, 32'd3);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_result", result, 0);
    @(negedge clk) rst_n = 1'b1;
    issue(3'd5, 32'd100, 32'd7);
    wait_done(lat, nb);
    chk("postrst_lat", lat, 33);
    chk("postrst_res", result, 32'd14);

    chk("busy_done_excl", overlap, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
